// File: rtl/cfg_loader.sv
// Configuration loader for the routing-mux switch block: takes words over a
// valid/ready handshake and strobes each DATA_SIZE-wide group of SRAM cells.
module cfg_loader #(
  parameter int DATA_SIZE    = 8,
  parameter int STROBE_SIZE  = 48,
  parameter int STROBE_WIDTH = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [DATA_SIZE-1:0]   IN_DATA,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [DATA_SIZE-1:0]   DATA,
  output logic [STROBE_SIZE-1:0] STROBE,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int NB_WORDS = (STROBE_SIZE + DATA_SIZE - 1) / DATA_SIZE;
  localparam int WCW      = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
  localparam int PCW      = (STROBE_WIDTH > 1) ? $clog2(STROBE_WIDTH) : 1;
  localparam logic [WCW-1:0] LAST_WORD  = WCW'(NB_WORDS - 1);
  localparam logic [PCW-1:0] LAST_PULSE = PCW'(STROBE_WIDTH - 1);

  // Handshake: a word transfers on any rising edge where IN_VALID and IN_READY
  // are both high; IN_READY is high only while waiting for the next word.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [WCW-1:0]       word, word_n;
  logic [PCW-1:0]       pulse, pulse_n;
  logic [DATA_SIZE-1:0] data_n;
  logic [STROBE_SIZE-1:0] strobe_n;
  logic                 done_n;

  always_comb begin
    state_n = state;
    word_n  = word;
    pulse_n = pulse;
    data_n  = DATA;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_n = WAIT;
          word_n  = '0;
        end
      end
      WAIT: begin
        if (IN_VALID && IN_READY) begin
          data_n  = IN_DATA;
          state_n = SETUP;
        end
      end
      SETUP: begin
        state_n = PULSE;
        pulse_n = '0;
      end
      PULSE: begin
        if (pulse == LAST_PULSE) state_n = HOLD;
        else                     pulse_n = pulse + 1'b1;
      end
      HOLD: begin
        if (word == LAST_WORD) begin
          state_n = IDLE;
          word_n  = '0;
          done_n  = 1'b1;
        end else begin
          word_n  = word + 1'b1;
          state_n = WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
    // Abort beats everything, including a handshake in the same cycle.
    if (ABORT && (state != IDLE)) begin
      state_n = IDLE;
      word_n  = '0;
      pulse_n = '0;
      data_n  = DATA;
      done_n  = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    strobe_n = '0;
    if (state_n == PULSE) begin
      for (int i = 0; i < STROBE_SIZE; i++) begin
        strobe_n[i] = ((i / DATA_SIZE) == int'(word_n));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      word     <= '0;
      pulse    <= '0;
      IN_READY <= 1'b0;
      DATA     <= '0;
      STROBE   <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_n;
      word     <= word_n;
      pulse    <= pulse_n;
      IN_READY <= (state_n == WAIT);
      DATA     <= data_n;
      STROBE   <= strobe_n;
      BUSY     <= (state_n != IDLE);
      DONE     <= done_n;
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader: a default instance (48 cells, 1-cycle strobe) and a
// remainder/stretch instance (20 cells, 3-cycle strobe) against a cell-level model.
module tb_cfg_loader;
  localparam int DW = 8;

  typedef struct {
    logic [47:0] mask;
    int          start;
    int          len;
    logic [7:0]  data;
  } pulse_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start [2];
  logic       abort [2];
  logic       in_valid [2];
  logic [7:0] in_data [2];

  logic        in_ready0, in_ready1, busy0, busy1, done0, done1;
  logic [7:0]  data0, data1;
  logic [47:0] strobe0;
  logic [19:0] strobe1;

  logic        rdy [2];
  logic        bsy [2];
  logic        dn [2];
  logic [7:0]  dat [2];
  logic [47:0] strb [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_q[$];
  pulse_t pq0[$], pq1[$];
  int dq0[$], dq1[$];
  logic [47:0] cells [2];
  logic [7:0]  prev_data [2];
  logic [47:0] run_mask [2];
  int          run_start [2];
  int          run_len [2];
  logic [7:0]  run_data [2];

  cfg_loader u_def (
    .CLK(clk), .RST(rst), .START(start[0]), .ABORT(abort[0]),
    .IN_DATA(in_data[0]), .IN_VALID(in_valid[0]), .IN_READY(in_ready0),
    .DATA(data0), .STROBE(strobe0), .BUSY(busy0), .DONE(done0)
  );

  cfg_loader #(.DATA_SIZE(8), .STROBE_SIZE(20), .STROBE_WIDTH(3)) u_rem (
    .CLK(clk), .RST(rst), .START(start[1]), .ABORT(abort[1]),
    .IN_DATA(in_data[1]), .IN_VALID(in_valid[1]), .IN_READY(in_ready1),
    .DATA(data1), .STROBE(strobe1), .BUSY(busy1), .DONE(done1)
  );

  always_comb begin
    rdy[0] = in_ready0;  rdy[1] = in_ready1;
    bsy[0] = busy0;      bsy[1] = busy1;
    dn[0]  = done0;      dn[1]  = done1;
    dat[0] = data0;      dat[1] = data1;
    strb[0] = strobe0;   strb[1] = {28'b0, strobe1};
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ss_of(input int s);
    return (s == 0) ? 48 : 20;
  endfunction

  function automatic int sw_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  function automatic int nb_of(input int s);
    return (ss_of(s) + DW - 1) / DW;
  endfunction

  function automatic logic [47:0] exp_mask(input int ss, input int w);
    logic [47:0] m;
    m = '0;
    for (int k = 0; k < DW; k++) if (w * DW + k < ss) m[w * DW + k] = 1'b1;
    return m;
  endfunction

  function automatic logic [47:0] exp_cells(input int ss, input logic [7:0] w [6]);
    logic [47:0] c;
    c = '0;
    for (int i = 0; i < ss; i++) c[i] = w[i / DW][i % DW];
    return c;
  endfunction

  // Monitor: protocol invariants, virtual SRAM cells, pulse and DONE logs.
  always @(negedge clk) begin : mon
    pulse_t p;
    for (int s = 0; s < 2; s++) begin
      if (strb[s] != '0) begin
        checks++;
        if ($countones(strb[s]) > DW || dat[s] !== prev_data[s]) begin
          failures++;
          $display("FAIL invariant dut%0d cyc=%0d: strobe=%h data=%h prev_data=%h",
                   s, cyc, strb[s], dat[s], prev_data[s]);
        end
        for (int i = 0; i < 48; i++) if (strb[s][i]) cells[s][i] = dat[s][i % DW];
      end
      if (strb[s] != '0 && run_len[s] > 0 && strb[s] == run_mask[s]) begin
        run_len[s]++;
      end else begin
        if (run_len[s] > 0) begin
          p.mask = run_mask[s]; p.start = run_start[s];
          p.len = run_len[s];   p.data = run_data[s];
          if (s == 0) pq0.push_back(p); else pq1.push_back(p);
        end
        if (strb[s] != '0) begin
          run_mask[s] = strb[s]; run_start[s] = cyc; run_len[s] = 1; run_data[s] = dat[s];
        end else begin
          run_len[s] = 0;
        end
      end
      if (dn[s] === 1'b1) begin
        if (s == 0) dq0.push_back(cyc); else dq1.push_back(cyc);
        checks++;
        if (bsy[s] !== 1'b0) begin
          failures++;
          $display("FAIL busy_in_done dut%0d: got %b expected 0", s, bsy[s]);
        end
      end
      prev_data[s] = dat[s];
    end
  end

  task automatic do_start(input int s, output int sc);
    start[s] = 1'b1;
    sc = cyc;
    @(negedge clk);
    start[s] = 1'b0;
  endtask

  // Sends n words; returns at the negedge of the last word's SETUP cycle.
  task automatic drive_words(input int s, input int n, input logic [7:0] w [6],
                             input int gap, output int stall_bad, output bit tmo);
    int budget;
    stall_bad = 0;
    tmo = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (gap > 0) begin
        in_valid[s] = 1'b0;
        budget = 0;
        while (rdy[s] !== 1'b1 && budget < 100) begin @(negedge clk); budget++; end
        if (budget >= 100) begin tmo = 1'b1; return; end
        for (int g = 0; g < gap; g++) begin
          if (rdy[s] !== 1'b1 || strb[s] !== '0) stall_bad++;
          @(negedge clk);
        end
      end
      in_valid[s] = 1'b1;
      in_data[s] = w[k];
      budget = 0;
      while (rdy[s] !== 1'b1 && budget < 100) begin @(negedge clk); budget++; end
      if (budget >= 100) begin in_valid[s] = 1'b0; tmo = 1'b1; return; end
      acc_q.push_back(cyc);
      @(negedge clk);
    end
    in_valid[s] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++; if (rdy[s] !== 1'b0) begin failures++; $display("FAIL reset_ready dut%0d: got %b expected 0", s, rdy[s]); end
      checks++; if (dat[s] !== 8'h00) begin failures++; $display("FAIL reset_data dut%0d: got %h expected 00", s, dat[s]); end
      checks++; if (strb[s] !== '0) begin failures++; $display("FAIL reset_strobe dut%0d: got %h expected 0", s, strb[s]); end
      checks++; if (bsy[s] !== 1'b0) begin failures++; $display("FAIL reset_busy dut%0d: got %b expected 0", s, bsy[s]); end
      checks++; if (dn[s] !== 1'b0) begin failures++; $display("FAIL reset_done dut%0d: got %b expected 0", s, dn[s]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_load;
    logic [7:0] w [6];
    logic [47:0] ec;
    int sc, sb;
    bit tmo;
    w = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    ec = exp_cells(48, w);
    pq0.delete(); dq0.delete(); acc_q.delete();
    cells[0] = ~ec;
    do_start(0, sc);
    fork
      drive_words(0, 6, w, 0, sb, tmo);
      begin repeat (7) @(negedge clk); start[0] = 1'b1; @(negedge clk); start[0] = 1'b0; end
    join
    repeat (6) @(negedge clk);
    checks++; if (tmo) begin failures++; $display("FAIL full_timeout: got 1 expected 0"); end
    checks++; if (pq0.size() != 6) begin failures++; $display("FAIL full_pulse_count: got %0d expected 6", pq0.size()); end
    for (int k = 0; k < 6 && k < pq0.size() && k < acc_q.size(); k++) begin
      checks++;
      if (pq0[k].mask !== exp_mask(48, k) || pq0[k].len != 1 || pq0[k].data !== w[k] ||
          pq0[k].start != acc_q[k] + 2) begin
        failures++;
        $display("FAIL full_pulse%0d: got mask=%h len=%0d data=%h start=%0d expected mask=%h len=1 data=%h start=%0d",
                 k, pq0[k].mask, pq0[k].len, pq0[k].data, pq0[k].start, exp_mask(48, k), w[k], acc_q[k] + 2);
      end
    end
    checks++;
    if (dq0.size() != 1 || dq0[0] != sc + 25) begin
      failures++;
      $display("FAIL full_done_cycle: got n=%0d first=%0d expected n=1 at %0d", dq0.size(),
               (dq0.size() > 0) ? dq0[0] - sc : -1, 25);
    end
    checks++; if (cells[0] !== ec) begin failures++; $display("FAIL full_cells: got %h expected %h", cells[0], ec); end
    checks++; if (dat[0] !== 8'h20 || bsy[0] !== 1'b0) begin failures++; $display("FAIL full_after: got data=%h busy=%b expected data=20 busy=0", dat[0], bsy[0]); end
  endtask

  task automatic test_remainder_stretch;
    logic [7:0] w [6];
    logic [47:0] ec;
    int sc, sb;
    bit tmo;
    w = '{8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h00};
    ec = exp_cells(20, w);
    pq1.delete(); dq1.delete(); acc_q.delete();
    cells[1] = ~ec;
    do_start(1, sc);
    drive_words(1, 3, w, 5, sb, tmo);
    repeat (8) @(negedge clk);
    checks++; if (tmo || sb != 0) begin failures++; $display("FAIL rem_stall: got timeout=%0d stall_errors=%0d expected 0 0", tmo, sb); end
    checks++; if (pq1.size() != 3) begin failures++; $display("FAIL rem_pulse_count: got %0d expected 3", pq1.size()); end
    for (int k = 0; k < 3 && k < pq1.size() && k < acc_q.size(); k++) begin
      checks++;
      if (pq1[k].mask !== exp_mask(20, k) || pq1[k].len != 3 || pq1[k].data !== w[k] ||
          pq1[k].start != acc_q[k] + 2) begin
        failures++;
        $display("FAIL rem_pulse%0d: got mask=%h len=%0d data=%h start=%0d expected mask=%h len=3 data=%h start=%0d",
                 k, pq1[k].mask, pq1[k].len, pq1[k].data, pq1[k].start, exp_mask(20, k), w[k], acc_q[k] + 2);
      end
    end
    checks++;
    if (acc_q.size() != 3 || dq1.size() != 1 || dq1[0] != acc_q[2] + 6) begin
      failures++;
      $display("FAIL rem_done: got n=%0d expected one DONE 6 cycles after last accept", dq1.size());
    end
    checks++; if ((cells[1] & 48'hF_FFFF) !== ec) begin failures++; $display("FAIL rem_cells: got %h expected %h", cells[1] & 48'hF_FFFF, ec); end
  endtask

  task automatic test_abort;
    logic [7:0] w [6];
    logic [47:0] ec;
    int sc, sb;
    bit tmo;
    for (int k = 0; k < 6; k++) w[k] = 8'($urandom_range(0, 255));
    pq0.delete(); dq0.delete(); acc_q.delete();
    do_start(0, sc);
    drive_words(0, 3, w, 0, sb, tmo);
    @(negedge clk);
    checks++; if (strb[0] !== exp_mask(48, 2)) begin failures++; $display("FAIL abort_in_pulse: got %h expected %h", strb[0], exp_mask(48, 2)); end
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    checks++;
    if (strb[0] !== '0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b0 || dn[0] !== 1'b0 || dat[0] !== w[2]) begin
      failures++;
      $display("FAIL abort_next: got strobe=%h busy=%b ready=%b done=%b data=%h expected 0 0 0 0 %h",
               strb[0], bsy[0], rdy[0], dn[0], dat[0], w[2]);
    end
    repeat (4) @(negedge clk);
    checks++; if (dq0.size() != 0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", dq0.size()); end

    for (int k = 0; k < 6; k++) w[k] = 8'($urandom_range(0, 255));
    ec = exp_cells(48, w);
    pq0.delete(); dq0.delete(); acc_q.delete();
    cells[0] = ~ec;
    do_start(0, sc);
    drive_words(0, 6, w, 0, sb, tmo);
    repeat (6) @(negedge clk);
    checks++;
    if (pq0.size() != 6 || pq0[0].mask !== 48'h0000_0000_00FF) begin
      failures++;
      $display("FAIL abort_reload_first: got n=%0d expected 6 pulses starting at group 00ff", pq0.size());
    end
    checks++; if (cells[0] !== ec) begin failures++; $display("FAIL abort_reload_cells: got %h expected %h", cells[0], ec); end
    checks++; if (dq0.size() != 1 || dq0[0] != sc + 25) begin failures++; $display("FAIL abort_reload_done: got n=%0d expected one DONE at +25", dq0.size()); end

    do_start(0, sc);
    in_valid[0] = 1'b1; in_data[0] = ~w[5]; abort[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0; abort[0] = 1'b0;
    checks++;
    if (bsy[0] !== 1'b0 || rdy[0] !== 1'b0 || dat[0] !== w[5]) begin
      failures++;
      $display("FAIL abort_with_handshake: got busy=%b ready=%b data=%h expected 0 0 %h", bsy[0], rdy[0], dat[0], w[5]);
    end

    start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; abort[0] = 1'b0;
    checks++; if (bsy[0] !== 1'b1 || rdy[0] !== 1'b1) begin failures++; $display("FAIL abort_idle_start: got busy=%b ready=%b expected 1 1", bsy[0], rdy[0]); end
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    checks++; if (bsy[0] !== 1'b0) begin failures++; $display("FAIL abort_wait: got busy=%b expected 0", bsy[0]); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] w [6];
    int sc, sb;
    bit tmo;
    for (int k = 0; k < 6; k++) w[k] = 8'($urandom_range(1, 255));
    pq0.delete(); dq0.delete(); acc_q.delete();
    do_start(0, sc);
    drive_words(0, 4, w, 0, sb, tmo);
    rst = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0; start[0] = 1'b0;
    checks++;
    if (rdy[0] !== 1'b0 || dat[0] !== 8'h00 || strb[0] !== '0 || bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got ready=%b data=%h strobe=%h busy=%b done=%b expected all 0",
               rdy[0], dat[0], strb[0], bsy[0], dn[0]);
    end
    @(negedge clk);
    checks++; if (bsy[0] !== 1'b0 || rdy[0] !== 1'b0) begin failures++; $display("FAIL reset_start_ignored: got busy=%b ready=%b expected 0 0", bsy[0], rdy[0]); end
    repeat (4) @(negedge clk);
    checks++; if (dq0.size() != 0) begin failures++; $display("FAIL reset_no_done: got %0d expected 0", dq0.size()); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w [6];
    logic [47:0] ec;
    int sc, sb, dc, budget;
    bit tmo;
    for (int k = 0; k < 6; k++) w[k] = 8'($urandom_range(0, 255));
    do_start(1, sc);
    drive_words(1, 3, w, 0, sb, tmo);
    budget = 0;
    while (dn[1] !== 1'b1 && budget < 20) begin @(negedge clk); budget++; end
    checks++; if (budget >= 20) begin failures++; $display("FAIL b2b_first_done: got none expected DONE"); end
    dc = cyc;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    checks++; if (bsy[1] !== 1'b1 || rdy[1] !== 1'b1) begin failures++; $display("FAIL b2b_start_on_done: got busy=%b ready=%b expected 1 1", bsy[1], rdy[1]); end
    for (int k = 0; k < 6; k++) w[k] = 8'($urandom_range(0, 255));
    ec = exp_cells(20, w);
    pq1.delete(); dq1.delete(); acc_q.delete();
    cells[1] = ~ec;
    drive_words(1, 3, w, 0, sb, tmo);
    repeat (8) @(negedge clk);
    checks++; if (dq1.size() != 1 || dq1[0] != dc + 1 + 3 * 6) begin failures++; $display("FAIL b2b_done: got n=%0d expected one DONE at +19", dq1.size()); end
    checks++; if ((cells[1] & 48'hF_FFFF) !== ec) begin failures++; $display("FAIL b2b_cells: got %h expected %h", cells[1] & 48'hF_FFFF, ec); end
  endtask

  task automatic test_random;
    logic [7:0] w [6];
    logic [47:0] ec, lim;
    pulse_t got[$];
    int dq[$];
    int s, sc, sb, nb, sw, gap;
    bit tmo;
    for (int r = 0; r < 6; r++) begin
      s = r % 2;
      nb = nb_of(s);
      sw = sw_of(s);
      gap = $urandom_range(0, 3);
      for (int k = 0; k < 6; k++) w[k] = 8'($urandom_range(0, 255));
      ec = exp_cells(ss_of(s), w);
      lim = (48'd1 << ss_of(s)) - 48'd1;
      pq0.delete(); pq1.delete(); dq0.delete(); dq1.delete(); acc_q.delete();
      cells[s] = ~ec;
      do_start(s, sc);
      drive_words(s, nb, w, gap, sb, tmo);
      repeat (sw + 6) @(negedge clk);
      if (s == 0) begin got = pq0; dq = dq0; end else begin got = pq1; dq = dq1; end
      checks++; if (tmo || sb != 0 || got.size() != nb) begin failures++; $display("FAIL rand%0d_pulses: got n=%0d stall_err=%0d expected n=%0d", r, got.size(), sb, nb); end
      for (int k = 0; k < nb && k < got.size() && k < acc_q.size(); k++) begin
        checks++;
        if (got[k].mask !== exp_mask(ss_of(s), k) || got[k].len != sw || got[k].data !== w[k] ||
            got[k].start != acc_q[k] + 2) begin
          failures++;
          $display("FAIL rand%0d_pulse%0d: got mask=%h len=%0d data=%h expected mask=%h len=%0d data=%h",
                   r, k, got[k].mask, got[k].len, got[k].data, exp_mask(ss_of(s), k), sw, w[k]);
        end
      end
      checks++;
      if (acc_q.size() != nb || dq.size() != 1 || dq[0] != acc_q[nb - 1] + 3 + sw) begin
        failures++;
        $display("FAIL rand%0d_done: got n=%0d expected one DONE %0d cycles after last accept", r, dq.size(), 3 + sw);
      end
      checks++; if ((cells[s] & lim) !== ec) begin failures++; $display("FAIL rand%0d_cells: got %h expected %h", r, cells[s] & lim, ec); end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; abort[s] = 1'b0; in_valid[s] = 1'b0; in_data[s] = 8'h00;
      cells[s] = '0; prev_data[s] = '0; run_mask[s] = '0; run_start[s] = 0; run_len[s] = 0; run_data[s] = '0;
    end
    test_reset;
    test_full_load;
    test_remainder_stretch;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
# cfg_loader

Configuration loader that sits directly upstream of the routing-mux switch block. It accepts a stream of DATA_SIZE-bit configuration words over a valid/ready handshake. For each word it drives the shared DATA bus and pulses the matching group of one-hot SRAM STROBE lines with setup and hold margin, so every SRAM cell in the switch block latches its select bit. One load sequence writes all STROBE_SIZE cells, then reports completion.

## Interface

**Parameters**
- DATA_SIZE, 8, width of the configuration word and of the DATA bus.
- STROBE_SIZE, 48, number of SRAM cells (strobe lines) in the downstream block.
- STROBE_WIDTH, 1, number of cycles each strobe group is held high; must be ≥1.
- NB_WORDS (derived), ceil(STROBE_SIZE/DATA_SIZE), words per load sequence; 1 when STROBE_SIZE ≤ DATA_SIZE.

**Ports**
- CLK  in  1  single clock; all logic rising-edge.
- RST  in  1  reset, synchronous and active-high.
- START  in  1  one-cycle request to begin a load sequence; ignored unless IDLE.
- ABORT  in  1  synchronous abort of a running sequence.
- IN_DATA  in  DATA_SIZE  configuration word.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  loader accepts a word this cycle.
- DATA  out  DATA_SIZE  word driven to the SRAM d inputs.
- STROBE  out  STROBE_SIZE  SRAM latch strobes, active-high.
- BUSY  out  1  sequence in progress (any state but IDLE).
- DONE  out  1  one-cycle pulse after the last word's hold cycle.

## Operation

- All outputs are registered. Reset values:
  - IN_READY = 0, DATA = 0, STROBE = 0, BUSY = 0, DONE = 0.
  - State = IDLE, word counter = 0.
- States: IDLE, WAIT, SETUP, PULSE, HOLD.
  - IDLE: on START, go to WAIT with counter = 0.
  - WAIT: IN_READY = 1. A transfer occurs when IN_VALID && IN_READY; the word is registered onto DATA and the state goes to SETUP. With IN_VALID low, stay in WAIT indefinitely with STROBE = 0.
  - SETUP: one cycle. DATA is stable, STROBE = 0.
  - PULSE: STROBE_WIDTH cycles. Strobe group w (w = counter) is high and all other STROBE bits are 0.
  - HOLD: one cycle. STROBE = 0 and DATA unchanged. If counter = NB_WORDS-1, go to IDLE and pulse DONE. Otherwise increment the counter and go to WAIT.
- Strobe group mapping: word w asserts STROBE[DATA_SIZE*w + k] for k = 0..DATA_SIZE-1. Cell DATA_SIZE*w + k therefore latches DATA[k].
- Last word when STROBE_SIZE % DATA_SIZE ≠ 0: only bits k < remainder are strobed. Upper DATA bits are still driven but have no effect.
- STROBE_SIZE ≤ DATA_SIZE: a single word strobes STROBE[STROBE_SIZE-1:0].
- At most one strobe group is ever high. STROBE is never high in the same cycle that DATA changes.
- DATA keeps its last value after DONE, until the next accepted word or reset.

## Timing

- A handshake at cycle t gives:
  - t+1: SETUP (DATA valid, strobes low).
  - t+2 … t+1+STROBE_WIDTH: PULSE.
  - t+2+STROBE_WIDTH: HOLD.
  - t+3+STROBE_WIDTH: either WAIT (IN_READY = 1) or, for the last word, IDLE with DONE = 1.
- Minimum cycles per word, counting the accept cycle: 3+STROBE_WIDTH.
- Minimum full sequence: 1 (START) + NB_WORDS*(3+STROBE_WIDTH) cycles to the DONE cycle. With default parameters this is 25.
- BUSY is 1 from the cycle after START through the last HOLD cycle. BUSY is 0 in the DONE cycle.
- ABORT (any non-IDLE state), effective next cycle:
  - STROBE = 0, IN_READY = 0, state = IDLE, counter = 0.
  - No DONE pulse, DATA unchanged.
  - ABORT in IDLE has no effect.
  - ABORT together with a handshake: ABORT wins and the word is dropped.
- RST mid-sequence: all outputs return to reset values on the next edge. RST overrides START and ABORT.
- START while BUSY is ignored. START in the same cycle as DONE is accepted, since the state is IDLE.

## Test plan

- **Full load, defaults:** START, then words 0x01, 0x02, 0x04, 0x08, 0x10, 0x20 with IN_VALID held high. Required:
  - STROBE pulses 0x0000_0000_00FF, 0x0000_0000_FF00, …, 0xFF00_0000_0000 in order, each one cycle wide.
  - DATA matches each word from its SETUP cycle through its HOLD cycle.
  - DONE fires exactly 25 cycles after START.
- **Remainder, STROBE_SIZE=20, DATA_SIZE=8:** three words 0xAA, 0x55, 0xFF. Required:
  - Groups 0x000FF, 0x0FF00, then 0xF0000 for the last word; bits above 19 never asserted.
  - DONE after the third HOLD.
- **Back-pressure and stretch, STROBE_WIDTH=3:** IN_VALID low for 5 cycles between words. Required:
  - IN_READY stays 1 and STROBE stays 0 for the whole stall.
  - Each pulse is exactly 3 cycles, with exactly one SETUP and one HOLD cycle around it.
- **Abort:** assert ABORT during the PULSE of word 2. Required:
  - Next cycle: STROBE = 0, BUSY = 0, no DONE.
  - A fresh START then reloads from word 0 (group 0x00FF first).
- **Reset mid-operation:** RST during SETUP of word 3. Required:
  - Next cycle all outputs are 0.
  - START asserted in the same cycle as RST is ignored.
- **Protocol invariants (all runs):** popcount(STROBE) ≤ DATA_SIZE. No DATA change in any cycle where STROBE ≠ 0. START while BUSY changes nothing.
